// File: rtl/ttt_pkg.sv
// ============================================================================
//  Module   : ttt_pkg
//  Brief    : Shared cell encoding, line table, FSM states and move-order
//             lists for the tic-tac-toe computer opponent.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ttt_pkg;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] PLAYER = 2'd1;
    localparam logic [1:0] COMP   = 2'd2;

    localparam logic [3:0] CENTRE = 4'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        SELECT   = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    // Rows, then columns, then diagonals; scan order sets first-match priority.
    localparam logic [3:0] LINE_TBL [0:7][0:2] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CORNER_ORDER [0:3] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] EDGE_ORDER   [0:3] = '{4'd1, 4'd3, 4'd5, 4'd7};

    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_line_eval.sv
// ============================================================================
//  Module   : ttt_line_eval
//  Brief    : Combinational check of one 3-cell line for a winning or
//             blocking move; reports which position holds the empty cell.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    output logic       win_hit,
    output logic       blk_hit,
    output logic [1:0] empty_pos
);

    logic [1:0] n_comp;
    logic [1:0] n_player;
    logic [1:0] n_empty;

    always_comb begin
        n_comp    = 2'd0;
        n_player  = 2'd0;
        n_empty   = 2'd0;
        empty_pos = 2'd0;
        if (cell_a == COMP)   n_comp   = n_comp + 2'd1;
        if (cell_b == COMP)   n_comp   = n_comp + 2'd1;
        if (cell_c == COMP)   n_comp   = n_comp + 2'd1;
        if (cell_a == PLAYER) n_player = n_player + 2'd1;
        if (cell_b == PLAYER) n_player = n_player + 2'd1;
        if (cell_c == PLAYER) n_player = n_player + 2'd1;
        if (cell_a == EMPTY)  n_empty  = n_empty + 2'd1;
        if (cell_b == EMPTY)  n_empty  = n_empty + 2'd1;
        if (cell_c == EMPTY)  n_empty  = n_empty + 2'd1;
        // Only meaningful when exactly one cell is empty.
        if (cell_a == EMPTY)      empty_pos = 2'd0;
        else if (cell_b == EMPTY) empty_pos = 2'd1;
        else                      empty_pos = 2'd2;
        win_hit = (n_comp == 2'd2) && (n_empty == 2'd1);
        blk_hit = (n_player == 2'd2) && (n_empty == 2'd1);
    end

endmodule

`default_nettype wire

// File: rtl/ttt_cpu_mover.sv
// ============================================================================
//  Module   : ttt_cpu_mover
//  Brief    : Computer opponent: snapshots the board, scans the 8 lines one
//             per cycle, then plays win > block > centre > corner > edge.
//             Define CPU_RANDOM_EN for an LFSR-randomised fallback move.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ttt_cpu_mover
    import ttt_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
`ifdef CPU_RANDOM_EN
    ,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] board_in,
    input  logic [1:0]  winner,
    input  logic        turn_req,
    output logic [3:0]  computer,
    output logic        comp_play,
    output logic        busy,
    output logic        no_move,
    output logic        ack_timeout
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [17:0]        board_q, board_d;
    logic [2:0]         line_q, line_d;
    logic               win_found_q, win_found_d;
    logic               blk_found_q, blk_found_d;
    logic [3:0]         win_idx_q, win_idx_d;
    logic [3:0]         blk_idx_q, blk_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         computer_q, computer_d;
    logic               comp_play_q, comp_play_d;
    logic               no_move_q, no_move_d;
    logic               ack_timeout_q, ack_timeout_d;

    logic [3:0]         lc_idx [0:2];
    logic [1:0]         lc_val [0:2];
    logic               line_win, line_blk;
    logic [1:0]         line_empty_pos;
    logic [3:0]         line_empty_cell;
    logic               pick_found;
    logic [3:0]         pick_idx;

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            lc_idx[j] = LINE_TBL[line_q][j];
            lc_val[j] = cell_at(board_q, lc_idx[j]);
        end
    end

    ttt_line_eval u_line_eval (
        .cell_a    (lc_val[0]),
        .cell_b    (lc_val[1]),
        .cell_c    (lc_val[2]),
        .win_hit   (line_win),
        .blk_hit   (line_blk),
        .empty_pos (line_empty_pos)
    );

    always_comb begin
        case (line_empty_pos)
            2'd1:    line_empty_cell = lc_idx[1];
            2'd2:    line_empty_cell = lc_idx[2];
            default: line_empty_cell = lc_idx[0];
        endcase
    end

`ifdef CPU_RANDOM_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] rand_start;
    logic [4:0] rand_sum;
    logic [3:0] rand_idx;

    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rand_start = 4'(lfsr_q % 8'd9);
    end

    always_ff @(posedge clk) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
`ifdef CPU_RANDOM_EN
        rand_sum   = 5'd0;
        rand_idx   = 4'd0;
`endif
        if (win_found_q) begin
            pick_found = 1'b1;
            pick_idx   = win_idx_q;
        end else if (blk_found_q) begin
            pick_found = 1'b1;
            pick_idx   = blk_idx_q;
        end else begin
`ifdef CPU_RANDOM_EN
            // Walk upward from the random start, wrapping 8 -> 0.
            for (int o = 0; o < 9; o++) begin
                rand_sum = {1'b0, rand_start} + 5'(o);
                rand_idx = (rand_sum >= 5'd9) ? 4'(rand_sum - 5'd9) : rand_sum[3:0];
                if (!pick_found && cell_at(board_q, rand_idx) == EMPTY) begin
                    pick_found = 1'b1;
                    pick_idx   = rand_idx;
                end
            end
`else
            if (cell_at(board_q, CENTRE) == EMPTY) begin
                pick_found = 1'b1;
                pick_idx   = CENTRE;
            end
            for (int i = 0; i < 4; i++) begin
                if (!pick_found && cell_at(board_q, CORNER_ORDER[i]) == EMPTY) begin
                    pick_found = 1'b1;
                    pick_idx   = CORNER_ORDER[i];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!pick_found && cell_at(board_q, EDGE_ORDER[i]) == EMPTY) begin
                    pick_found = 1'b1;
                    pick_idx   = EDGE_ORDER[i];
                end
            end
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        line_d        = line_q;
        win_found_d   = win_found_q;
        blk_found_d   = blk_found_q;
        win_idx_d     = win_idx_q;
        blk_idx_d     = blk_idx_q;
        cnt_d         = cnt_q;
        computer_d    = computer_q;
        comp_play_d   = comp_play_q;
        no_move_d     = 1'b0;
        ack_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (turn_req) begin
                    if (winner != 2'd0) begin
                        no_move_d = 1'b1;
                    end else begin
                        board_d     = board_in;
                        line_d      = 3'd0;
                        win_found_d = 1'b0;
                        blk_found_d = 1'b0;
                        state_d     = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!turn_req) begin
                    state_d = IDLE;
                end else begin
                    if (line_win && !win_found_q) begin
                        win_found_d = 1'b1;
                        win_idx_d   = line_empty_cell;
                    end
                    if (line_blk && !blk_found_q) begin
                        blk_found_d = 1'b1;
                        blk_idx_d   = line_empty_cell;
                    end
                    line_d = line_q + 3'd1;
                    if (line_q == 3'd7) state_d = SELECT;
                end
            end
            SELECT: begin
                if (!turn_req) begin
                    state_d = IDLE;
                end else if (pick_found) begin
                    computer_d  = pick_idx;
                    comp_play_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_ACK;
                end else begin
                    no_move_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_ACK: begin
                // The engine acknowledges by writing COMP into the chosen cell.
                if (!turn_req || winner != 2'd0 || cell_at(board_in, computer_q) == COMP) begin
                    comp_play_d = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    comp_play_d   = 1'b0;
                    ack_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            board_q       <= '0;
            line_q        <= '0;
            win_found_q   <= 1'b0;
            blk_found_q   <= 1'b0;
            win_idx_q     <= '0;
            blk_idx_q     <= '0;
            cnt_q         <= '0;
            computer_q    <= '0;
            comp_play_q   <= 1'b0;
            no_move_q     <= 1'b0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            line_q        <= line_d;
            win_found_q   <= win_found_d;
            blk_found_q   <= blk_found_d;
            win_idx_q     <= win_idx_d;
            blk_idx_q     <= blk_idx_d;
            cnt_q         <= cnt_d;
            computer_q    <= computer_d;
            comp_play_q   <= comp_play_d;
            no_move_q     <= no_move_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    assign computer    = computer_q;
    assign comp_play   = comp_play_q;
    assign busy        = (state_q != IDLE);
    assign no_move     = no_move_q;
    assign ack_timeout = ack_timeout_q;

endmodule

`default_nettype wire
